// File: rtl/lsu_dcache_arbiter_pkg.sv
// Shared types and constants for the LSU data-cache arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lsu_dcache_arbiter_pkg;

    localparam int DEFAULT_XLEN = 32;
    localparam int BYTE_EN_W    = 4;

    // Reads always fetch the whole word.
    localparam logic [BYTE_EN_W-1:0] BYTE_EN_ALL = '1;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_WAIT_RESP = 2'd1,
        ARB_DRAIN     = 2'd2
    } arb_state_t;

    // Index width for n items; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lsu_dcache_arbiter_rr_arbiter.sv
// Rotating-priority arbiter: the first set request at or after ptr wins.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides whether the grant is consumed.
//
// Ports:
//   req [W]  - request vector
//   ptr      - index holding highest priority, must be < W
//   gnt [W]  - one-hot grant, all zero when no request
module rr_arbiter
    import lsu_dcache_arbiter_pkg::*;
#(
    parameter int W = 3,
    localparam int PW = ptr_width(W)
) (
    input  logic [W-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [W-1:0]  gnt
);

    logic [2*W-1:0] req_dbl;
    logic [W-1:0]   req_rot;
    logic [W-1:0]   pick_rot;
    logic [2*W-1:0] gnt_dbl;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        req_dbl  = {req, req} >> ptr;
        req_rot  = req_dbl[W-1:0];
        pick_rot = req_rot & (~req_rot + 1'b1);
        gnt_dbl  = {{W{1'b0}}, pick_rot} << ptr;
        gnt      = gnt_dbl[W-1:0] | gnt_dbl[2*W-1:W];
    end

endmodule

// File: rtl/lsu_dcache_arbiter.sv
// Shares one data-cache port between NUM_LOAD load FUs and the store retire path.
// Latency: grant same cycle as request when cache_ready=1; load round trip 1+N cycles.
// Backpressure: cache_ready=0 holds the request with no grant; one load outstanding at a time.
//
// Ports:
//   clock, reset            - posedge clock, synchronous active-high reset
//   squash                  - pipeline flush pulse; masks new loads, kills the pending response
//   load_req/addr/grant     - per-FU load request, byte address, one-hot acceptance
//   load_resp_valid/data    - one-hot response strobe to the owning FU, shared data bus
//   store_req/addr/data/byte_en, store_grant - retire-path write and its acceptance
//   cache_req_*             - request toward the cache, accepted on valid & cache_ready
//   cache_resp_valid/data   - read data returning from the cache
module lsu_dcache_arbiter
    import lsu_dcache_arbiter_pkg::*;
#(
    parameter int NUM_LOAD = 2,
    parameter int XLEN     = DEFAULT_XLEN
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          squash,

    input  logic [NUM_LOAD-1:0]           load_req,
    input  logic [NUM_LOAD-1:0][XLEN-1:0] load_addr,
    output logic [NUM_LOAD-1:0]           load_grant,
    output logic [NUM_LOAD-1:0]           load_resp_valid,
    output logic [XLEN-1:0]               load_resp_data,

    input  logic                          store_req,
    input  logic [XLEN-1:0]               store_addr,
    input  logic [XLEN-1:0]               store_data,
    input  logic [BYTE_EN_W-1:0]          store_byte_en,
    output logic                          store_grant,

    output logic                          cache_req_valid,
    output logic                          cache_req_wr,
    output logic [XLEN-1:0]               cache_req_addr,
    output logic [XLEN-1:0]               cache_req_data,
    output logic [BYTE_EN_W-1:0]          cache_req_byte_en,
    input  logic                          cache_ready,
    input  logic                          cache_resp_valid,
    input  logic [XLEN-1:0]               cache_resp_data
);

    localparam int NREQ = NUM_LOAD + 1;          // store path is the last requester
    localparam int IW   = ptr_width(NREQ);
    localparam int OW   = ptr_width(NUM_LOAD);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [OW-1:0]   owner_q, owner_d;

    logic [NREQ-1:0] req_vec;
    logic [NREQ-1:0] gnt_vec;
    logic [IW-1:0]   win_idx;
    logic [XLEN-1:0] win_addr;
    logic            win_is_store;
    logic            issue;
    logic            accept;
    logic            resp_fire;

    // Squash only masks loads: a retired store is architectural and must still go out.
    assign req_vec = {store_req, load_req & ~{NUM_LOAD{squash}}};

    rr_arbiter #(
        .W (NREQ)
    ) u_rr_arbiter (
        .req (req_vec),
        .ptr (rr_ptr_q),
        .gnt (gnt_vec)
    );

    // Encode the one-hot winner and pick its word-aligned address.
    always_comb begin
        win_idx  = '0;
        win_addr = '0;
        for (int i = 0; i < NUM_LOAD; i++) begin
            if (gnt_vec[i]) begin
                win_idx  = IW'(i);
                win_addr = load_addr[i] & ALIGN_MASK;
            end
        end
        if (gnt_vec[NUM_LOAD]) begin
            win_idx  = IW'(NUM_LOAD);
            win_addr = store_addr & ALIGN_MASK;
        end
    end

    assign win_is_store = gnt_vec[NUM_LOAD];

    // All outputs are forced quiet while reset is held, including the
    // combinational paths from requesters and the cache response.
    assign issue     = ~reset & (state_q == ARB_IDLE) & (|req_vec);
    assign accept    = issue & cache_ready;
    // A response coinciding with squash belongs to a killed load and is dropped.
    assign resp_fire = ~reset & (state_q == ARB_WAIT_RESP) & cache_resp_valid & ~squash;

    always_comb begin
        cache_req_valid   = issue;
        cache_req_wr      = issue & win_is_store;
        cache_req_addr    = issue ? win_addr : '0;
        cache_req_data    = (issue & win_is_store) ? store_data : '0;
        cache_req_byte_en = (issue & win_is_store) ? store_byte_en : BYTE_EN_ALL;

        load_grant        = accept ? gnt_vec[NUM_LOAD-1:0] : '0;
        store_grant       = accept & win_is_store;

        load_resp_valid   = '0;
        if (resp_fire) begin
            load_resp_valid[owner_q] = 1'b1;
        end
        load_resp_data    = resp_fire ? cache_resp_data : '0;
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        case (state_q)
            ARB_IDLE: begin
                // A stalled request leaves rr_ptr alone so the same priority
                // order is re-evaluated next cycle.
                if (accept) begin
                    rr_ptr_d = win_is_store ? '0 : win_idx + 1'b1;
                    if (!win_is_store) begin
                        owner_d = win_idx[OW-1:0];
                        state_d = ARB_WAIT_RESP;
                    end
                end
            end
            ARB_WAIT_RESP: begin
                if (cache_resp_valid) begin
                    state_d = ARB_IDLE;
                end else if (squash) begin
                    state_d = ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                // The cache still owes one response; swallow it before reissuing.
                if (cache_resp_valid) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
        end
    end

endmodule
